// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : single-outstanding request sequencer for a 512x32
//                   registered-read RAM, with saturating debug counters.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RD_ISSUE   = 2'd1,
    RD_CAPTURE = 2'd2,
    WR_ISSUE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                ram_read_q, ram_read_d;
  logic                ram_write_q, ram_write_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]    rd_count_q, rd_count_d;
  logic [CNT_W-1:0]    wr_count_q, wr_count_d;

  always_comb begin
    state_d     = state_q;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ram_addr_d  = req_addr;
          ram_wdata_d = req_wdata;
          // Strobes are registered, so they rise together with the new state.
          if (req_write) begin
            state_d     = WR_ISSUE;
            ram_write_d = 1'b1;
          end else begin
            state_d    = RD_ISSUE;
            ram_read_d = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        state_d = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        rsp_rdata_d = ram_rdata;
        rsp_valid_d = 1'b1;
        if (rd_count_q != {CNT_W{1'b1}}) rd_count_d = rd_count_q + CNT_W'(1);
        state_d     = IDLE;
      end
      WR_ISSUE: begin
        rsp_valid_d = 1'b1;
        if (wr_count_q != {CNT_W{1'b1}}) wr_count_d = wr_count_q + CNT_W'(1);
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl : directed vector bench with a registered-read RAM model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              clr;
  logic              req_valid, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready, rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              ram_read, ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [CNT_W-1:0]  rd_count, wr_count;

  int tests = 0;
  int fails = 0;
  int strobe_clash = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .rd_count(rd_count), .wr_count(wr_count)
  );

  // Synchronous RAM with one-cycle registered read
  logic [DATA_W-1:0] mem [512];
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_wdata;
    if (ram_read)  ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) if (ram_read && ram_write) strobe_clash++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic transact(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          output int lat, output int nrd, output int nwr,
                          output logic addr_ok, output logic wd_ok);
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    lat = -1; nrd = 0; nwr = 0; addr_ok = 1'b1; wd_ok = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 0) req_valid = 1'b0;
      if (ram_read) begin
        nrd++;
        if (ram_addr !== a) addr_ok = 1'b0;
      end
      if (ram_write) begin
        nwr++;
        if (ram_addr !== a) addr_ok = 1'b0;
        if (ram_wdata !== d) wd_ok = 1'b0;
      end
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  typedef struct {
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_rdata;
    int                exp_rd;
    int                exp_wr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, nrd, nwr, rsp_seen;
    logic aok, wok;

    for (int i = 0; i < 512; i++) mem[i] = '0;
    // Write/read mix; counters saturate at 3 with CNT_W = 2
    vecs[0] = '{1'b1, 9'h050, 32'hDEADBEEF, 32'h00000000, 0, 1};
    vecs[1] = '{1'b0, 9'h050, 32'h0,        32'hDEADBEEF, 1, 1};
    vecs[2] = '{1'b1, 9'h1FF, 32'hA5A5A5A5, 32'hDEADBEEF, 1, 2};
    vecs[3] = '{1'b1, 9'h000, 32'h00000001, 32'hDEADBEEF, 1, 3};
    vecs[4] = '{1'b0, 9'h1FF, 32'h0,        32'hA5A5A5A5, 2, 3};
    vecs[5] = '{1'b0, 9'h000, 32'h0,        32'h00000001, 3, 3};
    vecs[6] = '{1'b1, 9'h000, 32'hCAFEF00D, 32'h00000001, 3, 3};
    vecs[7] = '{1'b0, 9'h000, 32'h0,        32'hCAFEF00D, 3, 3};
    vecs[8] = '{1'b0, 9'h050, 32'h0,        32'hDEADBEEF, 3, 3};

    clr = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    #3;
    check("rst_ready",   {31'b0, req_ready}, 32'd1);
    check("rst_rsp_v",   {31'b0, rsp_valid}, 32'd0);
    check("rst_strobes", {30'b0, ram_read, ram_write}, 32'd0);
    check("rst_rdata",   rsp_rdata, 32'd0);
    check("rst_counts",  {28'b0, rd_count, wr_count}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      transact(vecs[i].w, vecs[i].a, vecs[i].d, lat, nrd, nwr, aok, wok);
      check($sformatf("v%0d_latency", i), lat, vecs[i].w ? 32'd1 : 32'd2);
      check($sformatf("v%0d_rd_strobes", i), nrd, vecs[i].w ? 32'd0 : 32'd1);
      check($sformatf("v%0d_wr_strobes", i), nwr, vecs[i].w ? 32'd1 : 32'd0);
      check($sformatf("v%0d_addr", i), {31'b0, aok}, 32'd1);
      check($sformatf("v%0d_wdata", i), {31'b0, wok}, 32'd1);
      check($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_rd_count", i), {30'b0, rd_count}, vecs[i].exp_rd);
      check($sformatf("v%0d_wr_count", i), {30'b0, wr_count}, vecs[i].exp_wr);
      check($sformatf("v%0d_ready_rsp", i), {31'b0, req_ready}, 32'd1);
    end

    // Request held while busy must wait for IDLE and execute exactly once
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h050;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b1; req_wdata = 32'h11111111;
    check("busy_ready_issue", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("busy_ready_capture", {31'b0, req_ready}, 32'd0);
    check("busy_no_early_rsp", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("busy_read_rsp", {31'b0, rsp_valid}, 32'd1);
    check("busy_read_data", rsp_rdata, 32'hDEADBEEF);
    check("busy_ready_rsp", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_held_write_strobe", {31'b0, ram_write}, 32'd1);
    check("busy_no_dup_rsp", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("busy_write_rsp", {31'b0, rsp_valid}, 32'd1);
    check("busy_rdata_held", rsp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    check("busy_rsp_single", {31'b0, rsp_valid}, 32'd0);
    transact(1'b0, 9'h050, 32'h0, lat, nrd, nwr, aok, wok);
    check("busy_readback_lat", lat, 32'd2);
    check("busy_readback_data", rsp_rdata, 32'h11111111);

    // Asynchronous clear during WR_ISSUE aborts the write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h1FF; req_wdata = 32'h12345678;
    @(posedge clk);
    #2;
    check("abort_pre_strobe", {31'b0, ram_write}, 32'd1);
    clr = 1'b1;
    #1;
    check("abort_ready",   {31'b0, req_ready}, 32'd1);
    check("abort_rsp_v",   {31'b0, rsp_valid}, 32'd0);
    check("abort_strobes", {30'b0, ram_read, ram_write}, 32'd0);
    check("abort_rdata",   rsp_rdata, 32'd0);
    check("abort_addr",    {23'b0, ram_addr}, 32'd0);
    check("abort_wdata",   ram_wdata, 32'd0);
    check("abort_counts",  {28'b0, rd_count, wr_count}, 32'd0);
    @(negedge clk);
    check("abort_ignored_in_clr", {30'b0, ram_read, ram_write}, 32'd0);
    req_valid = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    check("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    transact(1'b0, 9'h1FF, 32'h0, lat, nrd, nwr, aok, wok);
    check("abort_old_data", rsp_rdata, 32'hA5A5A5A5);
    check("abort_rd_count", {30'b0, rd_count}, 32'd1);
    check("abort_wr_count", {30'b0, wr_count}, 32'd0);

    // Clear during an in-flight read suppresses its response
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h000;
    @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    check("rdabort_strobe", {31'b0, ram_read}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    clr = 1'b0;
    rsp_seen = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    check("rdabort_no_rsp", rsp_seen, 32'd0);
    check("rdabort_rd_count", {30'b0, rd_count}, 32'd0);
    check("rdabort_ready", {31'b0, req_ready}, 32'd1);

    check("strobe_exclusive", strobe_clash, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
